// File: rtl/bp_me_dram_stream_responder.sv
// Streamed DRAM responder: accepts a command header (+ write beats), commits to a
// word-addressed backing store, and answers with a response header (+ read beats).
module bp_me_dram_stream_responder
    #(parameter int paddr_width_p     = 40
    , parameter int dword_width_p     = 64
    , parameter int cce_block_width_p = 512
    , parameter int payload_width_p   = 16
    , parameter int mem_els_p         = 4096
    , localparam int dram_mem_msg_header_width_lp = payload_width_p + paddr_width_p + 3 + 4
    )
    (input  logic                                    clk_i
    , input  logic                                    reset_i

    , input  logic [dram_mem_msg_header_width_lp-1:0] mem_cmd_header_i
    , input  logic                                    mem_cmd_header_v_i
    , output logic                                    mem_cmd_header_yumi_o
    , input  logic [dword_width_p-1:0]                mem_cmd_data_i
    , input  logic                                    mem_cmd_data_v_i
    , output logic                                    mem_cmd_data_yumi_o

    , output logic [dram_mem_msg_header_width_lp-1:0] mem_resp_header_o
    , output logic                                    mem_resp_header_v_o
    , input  logic                                    mem_resp_header_ready_i
    , output logic [dword_width_p-1:0]                mem_resp_data_o
    , output logic                                    mem_resp_data_v_o
    , input  logic                                    mem_resp_data_ready_i
    );

    localparam int max_beats_lp  = cce_block_width_p / dword_width_p;
    localparam int max_log_lp    = $clog2(max_beats_lp);
    localparam int cnt_width_lp  = $clog2(max_beats_lp + 1);
    localparam int idx_width_lp  = $clog2(mem_els_p);
    localparam int byte_off_lp   = $clog2(dword_width_p / 8);
    localparam int size_lsb_lp   = 4;
    localparam int addr_lsb_lp   = 7;

    localparam logic [3:0] e_mem_msg_wr     = 4'd1;
    localparam logic [2:0] e_mem_msg_size_8 = 3'd3;

    typedef enum logic [2:0] {
        e_ready,
        e_wr_data,
        e_wr_resp,
        e_rd_header,
        e_rd_data
    } state_e;

    state_e                                  state_reg, state_next;
    logic [dram_mem_msg_header_width_lp-1:0] header_reg;
    logic [cnt_width_lp-1:0]                 count_reg;
    logic [dword_width_p-1:0]                mem [mem_els_p];

    logic [2:0]              hdr_size;
    logic [cnt_width_lp-1:0] beats;
    logic                    last_beat;
    logic [idx_width_lp-1:0] idx;

    assign hdr_size = header_reg[size_lsb_lp +: 3];

    // Beat count from the size code, clamped to one cache block.
    always_comb begin
        beats = cnt_width_lp'(1);
        if (hdr_size >= e_mem_msg_size_8) begin
            if ((hdr_size - e_mem_msg_size_8) >= 3'(max_log_lp))
                beats = cnt_width_lp'(max_beats_lp);
            else
                beats = cnt_width_lp'(1) << (hdr_size - e_mem_msg_size_8);
        end
    end

    assign last_beat = (count_reg == beats - 1'b1);
    // Index wraps naturally by truncation to the store depth.
    assign idx = header_reg[addr_lsb_lp + byte_off_lp +: idx_width_lp] + idx_width_lp'(count_reg);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg  <= e_ready;
            header_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (mem_cmd_header_yumi_o) begin
                header_reg <= mem_cmd_header_i;
                count_reg  <= '0;
            end else if (mem_cmd_data_yumi_o || (mem_resp_data_v_o && mem_resp_data_ready_i)) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            e_ready:
                if (mem_cmd_header_yumi_o)
                    state_next = (mem_cmd_header_i[3:0] == e_mem_msg_wr) ? e_wr_data : e_rd_header;
            e_wr_data:
                if (mem_cmd_data_yumi_o && last_beat)
                    state_next = e_wr_resp;
            e_wr_resp:
                if (mem_resp_header_v_o && mem_resp_header_ready_i)
                    state_next = e_ready;
            e_rd_header:
                if (mem_resp_header_v_o && mem_resp_header_ready_i)
                    state_next = e_rd_data;
            e_rd_data:
                if (mem_resp_data_v_o && mem_resp_data_ready_i && last_beat)
                    state_next = e_ready;
            default:
                state_next = e_ready;
        endcase
    end

    // Handshakes are gated by reset so nothing is consumed or offered while it is held.
    always_comb begin
        mem_cmd_header_yumi_o = 1'b0;
        mem_cmd_data_yumi_o   = 1'b0;
        mem_resp_header_v_o   = 1'b0;
        mem_resp_data_v_o     = 1'b0;
        case (state_reg)
            e_ready:     mem_cmd_header_yumi_o = mem_cmd_header_v_i & ~reset_i;
            e_wr_data:   mem_cmd_data_yumi_o   = mem_cmd_data_v_i & ~reset_i;
            e_wr_resp,
            e_rd_header: mem_resp_header_v_o   = ~reset_i;
            e_rd_data:   mem_resp_data_v_o     = ~reset_i;
            default:     ;
        endcase
    end

    assign mem_resp_header_o = header_reg;
    assign mem_resp_data_o   = mem[idx];

    always_ff @(posedge clk_i) begin
        if (mem_cmd_data_yumi_o)
            mem[idx] <= mem_cmd_data_i;
    end

endmodule

// File: tb/tb_bp_me_dram_stream_responder.sv
// Scoreboarded random + directed bench for the streamed DRAM responder.
module tb_bp_me_dram_stream_responder;

    localparam int PW  = 40;
    localparam int DW  = 64;
    localparam int BW  = 512;
    localparam int PLW = 16;
    localparam int ELS = 16;
    localparam int HW  = PLW + PW + 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i;
    logic [HW-1:0] cmd_header;
    logic          cmd_header_v;
    logic          cmd_header_yumi;
    logic [DW-1:0] cmd_data;
    logic          cmd_data_v;
    logic          cmd_data_yumi;
    logic [HW-1:0] resp_header;
    logic          resp_header_v;
    logic          resp_header_ready;
    logic [DW-1:0] resp_data;
    logic          resp_data_v;
    logic          resp_data_ready;

    bp_me_dram_stream_responder #(
        .paddr_width_p(PW), .dword_width_p(DW), .cce_block_width_p(BW),
        .payload_width_p(PLW), .mem_els_p(ELS)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .mem_cmd_header_i(cmd_header), .mem_cmd_header_v_i(cmd_header_v),
        .mem_cmd_header_yumi_o(cmd_header_yumi),
        .mem_cmd_data_i(cmd_data), .mem_cmd_data_v_i(cmd_data_v),
        .mem_cmd_data_yumi_o(cmd_data_yumi),
        .mem_resp_header_o(resp_header), .mem_resp_header_v_o(resp_header_v),
        .mem_resp_header_ready_i(resp_header_ready),
        .mem_resp_data_o(resp_data), .mem_resp_data_v_o(resp_data_v),
        .mem_resp_data_ready_i(resp_data_ready)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] ref_mem [ELS];
    logic [DW-1:0] wdata [8];
    logic [HW-1:0] exp_hdr_q [$];
    logic [DW-1:0] exp_data_q [$];
    bit            rand_ready = 1'b0;
    bit            expect_no_hdr_yumi = 1'b0;

    function automatic logic [HW-1:0] mk_hdr(logic [3:0] t, logic [2:0] s, logic [PW-1:0] a, logic [PLW-1:0] p);
        return {p, a, s, t};
    endfunction

    function automatic int n_beats(int size);
        int b;
        if (size < 3) return 1;
        b = 1 << (size - 3);
        return (b > BW / DW) ? BW / DW : b;
    endfunction

    function automatic int word_of(logic [PW-1:0] a, int i);
        logic [PW-1:0] w;
        w = ((a >> 3) + PW'(i)) % PW'(ELS);
        return int'(w);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting for DUT", name);
    endtask

    task automatic send_header(logic [HW-1:0] hdr);
        int n;
        cmd_header   = hdr;
        cmd_header_v = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_header_yumi) begin
            n++;
            if (n > 2000) begin
                timeout("cmd_header_yumi");
                cmd_header_v = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        cmd_header_v = 1'b0;
    endtask

    task automatic send_beat(logic [DW-1:0] d, bit gap);
        int n;
        if (gap) begin
            cmd_data_v = 1'b0;
            @(posedge clk); #1;
        end
        cmd_data   = d;
        cmd_data_v = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_data_yumi) begin
            n++;
            if (n > 2000) begin
                timeout("cmd_data_yumi");
                cmd_data_v = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        cmd_data_v = 1'b0;
    endtask

    // gapmode: 0 back-to-back, 1 idle cycle before each beat, 2 random idles
    task automatic issue_write(int size, logic [PW-1:0] addr, logic [PLW-1:0] pay, int gapmode);
        int nb;
        logic [HW-1:0] h;
        nb = n_beats(size);
        h  = mk_hdr(4'd1, 3'(size), addr, pay);
        exp_hdr_q.push_back(h);
        for (int i = 0; i < nb; i++) ref_mem[word_of(addr, i)] = wdata[i];
        send_header(h);
        for (int i = 0; i < nb; i++)
            send_beat(wdata[i], gapmode == 1 ? 1'b1 : (gapmode == 2 ? 1'($urandom_range(0, 1)) : 1'b0));
    endtask

    task automatic push_read(logic [HW-1:0] h, int size, logic [PW-1:0] addr);
        exp_hdr_q.push_back(h);
        for (int i = 0; i < n_beats(size); i++) exp_data_q.push_back(ref_mem[word_of(addr, i)]);
    endtask

    task automatic issue_read(logic [3:0] t, int size, logic [PW-1:0] addr, logic [PLW-1:0] pay);
        logic [HW-1:0] h;
        h = mk_hdr(t, 3'(size), addr, pay);
        push_read(h, size, addr);
        send_header(h);
    endtask

    // Read with downstream always ready: header one cycle after accept, beats back-to-back.
    task automatic read_lat(int size, logic [PW-1:0] addr);
        issue_read(4'd0, size, addr, 16'(size));
        @(negedge clk);
        chk("rd_lat_hdr_v", 64'(resp_header_v), 64'd1);
        for (int i = 0; i < n_beats(size); i++) begin
            @(negedge clk);
            chk("rd_lat_data_v", 64'(resp_data_v), 64'd1);
        end
        @(negedge clk);
        chk("rd_done_data_v", 64'(resp_data_v), 64'd0);
        chk("rd_done_hdr_v", 64'(resp_header_v), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic write_lat(int size, logic [PW-1:0] addr, int gapmode);
        issue_write(size, addr, 16'hA5A5, gapmode);
        @(negedge clk);
        chk("wr_lat_hdr_v", 64'(resp_header_v), 64'd1);
        @(posedge clk); #1;
    endtask

    // Ready driver
    initial begin
        resp_header_ready = 1'b1;
        resp_data_ready   = 1'b1;
        forever begin
            @(posedge clk); #1;
            resp_header_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            resp_data_ready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expectations on every handshake and checks stall stability.
    initial begin
        bit            hdr_stall  = 1'b0;
        bit            data_stall = 1'b0;
        logic [HW-1:0] hdr_hold   = '0;
        logic [DW-1:0] data_hold  = '0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                hdr_stall  = 1'b0;
                data_stall = 1'b0;
            end else begin
                if (expect_no_hdr_yumi) chk("hdr_yumi_blocked", 64'(cmd_header_yumi), 64'd0);
                if (hdr_stall) begin
                    chk("hdr_hold_v", 64'(resp_header_v), 64'd1);
                    chk("hdr_hold_val", 64'(resp_header), 64'(hdr_hold));
                end
                if (data_stall) begin
                    chk("data_hold_v", 64'(resp_data_v), 64'd1);
                    chk("data_hold_val", resp_data, data_hold);
                end
                if (resp_header_v && resp_header_ready) begin
                    if (exp_hdr_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL resp_header unexpected actual=%h required=none", resp_header);
                    end else begin
                        chk("resp_header", 64'(resp_header), 64'(exp_hdr_q.pop_front()));
                    end
                end
                if (resp_data_v && resp_data_ready) begin
                    if (exp_data_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL resp_data unexpected actual=%h required=none", resp_data);
                    end else begin
                        chk("resp_data", resp_data, exp_data_q.pop_front());
                    end
                end
                hdr_stall  = resp_header_v && !resp_header_ready;
                hdr_hold   = resp_header;
                data_stall = resp_data_v && !resp_data_ready;
                data_hold  = resp_data;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [HW-1:0] h;
        int n;
        reset_i      = 1'b1;
        cmd_header   = mk_hdr(4'd0, 3'd3, 40'h0, 16'h0);
        cmd_header_v = 1'b1;
        cmd_data     = '0;
        cmd_data_v   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hdr_yumi", 64'(cmd_header_yumi), 64'd0);
        chk("reset_data_yumi", 64'(cmd_data_yumi), 64'd0);
        chk("reset_resp_hdr_v", 64'(resp_header_v), 64'd0);
        chk("reset_resp_data_v", 64'(resp_data_v), 64'd0);
        @(posedge clk); #1;
        reset_i      = 1'b0;
        cmd_header_v = 1'b0;
        @(negedge clk);
        chk("reset_resp_header", 64'(resp_header), 64'd0);
        chk("ready_data_not_consumed", 64'(cmd_data_yumi), 64'd0);
        @(posedge clk); #1;
        cmd_data_v = 1'b0;

        // Fill the whole store so every later read has a defined model value.
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 8; i++) wdata[i] = {$urandom, $urandom};
            issue_write(6, PW'(b * 64), 16'(b), 0);
        end

        // Block write with gapped beats, then read it back.
        for (int i = 0; i < 8; i++) wdata[i] = 64'(8'h11 * (i + 1));
        write_lat(6, 40'h0080000040, 1);
        read_lat(6, 40'h0080000040);

        // Single-dword write/read.
        wdata[0] = 64'hDEAD_BEEF;
        write_lat(3, 40'h10, 0);
        read_lat(3, 40'h10);
        read_lat(1, 40'h14);

        // Wrap: 8 beats at word 12 land on 12..15, 0..3.
        for (int i = 0; i < 8; i++) wdata[i] = {32'hC0DE0000 + 32'(i), $urandom};
        write_lat(6, 40'h60, 0);
        read_lat(3, 40'h0);
        read_lat(7, 40'h60);

        // Random downstream backpressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 4; k++) issue_read(4'($urandom_range(0, 5) == 1 ? 0 : $urandom_range(2, 5)), 6, PW'($urandom), 16'(k));

        // Second header presented while a write is still collecting beats.
        for (int i = 0; i < 8; i++) wdata[i] = {$urandom, $urandom};
        h = mk_hdr(4'd1, 3'd6, 40'h100, 16'h2222);
        exp_hdr_q.push_back(h);
        for (int i = 0; i < 8; i++) ref_mem[word_of(40'h100, i)] = wdata[i];
        send_header(h);
        h = mk_hdr(4'd0, 3'd6, 40'h100, 16'h3333);
        push_read(h, 6, 40'h100);
        cmd_header   = h;
        cmd_header_v = 1'b1;
        expect_no_hdr_yumi = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(wdata[i], 1'b1);
        n = 0;
        @(negedge clk);
        while (!(resp_header_v && resp_header_ready) && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) timeout("wr_resp_handshake");
        expect_no_hdr_yumi = 1'b0;
        @(negedge clk);
        chk("hdr_accept_after_resp", 64'(cmd_header_yumi), 64'd1);
        @(posedge clk); #1;
        cmd_header_v = 1'b0;

        // Reset mid-write: no response, three beats stay written.
        n = 0;
        while ((exp_hdr_q.size() != 0 || exp_data_q.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        rand_ready = 1'b0;
        for (int i = 0; i < 8; i++) wdata[i] = {32'hABCD0000 + 32'(i), $urandom};
        send_header(mk_hdr(4'd1, 3'd6, 40'h20, 16'h4444));
        for (int i = 0; i < 3; i++) begin
            ref_mem[word_of(40'h20, i)] = wdata[i];
            send_beat(wdata[i], 1'b0);
        end
        reset_i    = 1'b1;
        cmd_data   = wdata[3];
        cmd_data_v = 1'b1;
        @(negedge clk);
        chk("abort_data_yumi", 64'(cmd_data_yumi), 64'd0);
        @(posedge clk); #1;
        reset_i    = 1'b0;
        cmd_data_v = 1'b0;
        @(negedge clk);
        chk("abort_resp_hdr_v", 64'(resp_header_v), 64'd0);
        chk("abort_resp_data_v", 64'(resp_data_v), 64'd0);
        chk("abort_data_yumi_after", 64'(cmd_data_yumi), 64'd0);
        @(posedge clk); #1;
        h = mk_hdr(4'd0, 3'd6, 40'h20, 16'h5555);
        push_read(h, 6, 40'h20);
        cmd_header   = h;
        cmd_header_v = 1'b1;
        @(negedge clk);
        chk("post_reset_accept", 64'(cmd_header_yumi), 64'd1);
        @(posedge clk); #1;
        cmd_header_v = 1'b0;

        // Random traffic.
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int sz;
            logic [3:0] t;
            sz = $urandom_range(0, 7);
            t  = 4'($urandom_range(0, 5));
            if (t == 4'd1) begin
                for (int i = 0; i < 8; i++) wdata[i] = {$urandom, $urandom};
                issue_write(sz, PW'($urandom), 16'($urandom), 2);
            end else begin
                issue_read(t, sz, PW'($urandom), 16'($urandom));
            end
        end

        n = 0;
        while ((exp_hdr_q.size() != 0 || exp_data_q.size() != 0) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_hdr_q", 64'(exp_hdr_q.size()), 64'd0);
        chk("drain_data_q", 64'(exp_data_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_me_dram_stream_responder.md
Name: bp_me_dram_stream_responder

Overview:
- DRAM-side responder for the streamed memory interface that an L2 cache slice drives on its DMA side.
- Accepts a command header plus, for writes, a stream of dword data beats. Commits the data to an internal word-addressed backing store.
- Returns a response header plus, for reads, a stream of dword data beats.
- Used as the memory endpoint in cache-slice testbenches and as a small on-chip scratch memory behind a slice.

Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration. Supplies paddr_width_p, dword_width_p, cce_block_width_p and the dram_mem header layout.
- mem_els_p, 4096, backing store depth in dwords; power of two, at least cce_block_width_p/dword_width_p.
- max_beats_lp, cce_block_width_p/dword_width_p, local; maximum beats per message.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- mem_cmd_header_i  in  dram_mem_msg_header_width_lp  command header (msg_type, size, addr, payload).
- mem_cmd_header_v_i  in  1  header valid.
- mem_cmd_header_yumi_o  out  1  header consumed this cycle.
- mem_cmd_data_i  in  dword_width_p  write data beat.
- mem_cmd_data_v_i  in  1  data beat valid.
- mem_cmd_data_yumi_o  out  1  data beat consumed this cycle.
- mem_resp_header_o  out  dram_mem_msg_header_width_lp  response header.
- mem_resp_header_v_o  out  1  response header valid.
- mem_resp_header_ready_i  in  1  downstream can take the header.
- mem_resp_data_o  out  dword_width_p  read data beat.
- mem_resp_data_v_o  out  1  read beat valid.
- mem_resp_data_ready_i  in  1  downstream can take the beat.

Behaviour:
- Reset: all v/yumi outputs 0; state e_ready; beat counter 0; header register 0. The backing store is not reset.
- Reset asserted mid-transaction aborts it: no response is issued and any partially written block is left as written.
- Beats per message = 2^(size-3) when size >= e_mem_msg_size_8, else 1; clamped to max_beats_lp.
  - Sub-dword writes write the full dword.
- Word index for beat i = ((addr >> log2(dword_width_p/8)) + i) mod mem_els_p. Addresses past the store wrap; no error is raised.
- FSM states:
  - e_ready: mem_cmd_header_yumi_o = mem_cmd_header_v_i. On a yumi, latch the header and clear the counter. Go to e_wr_data if msg_type == e_mem_msg_wr, else to e_rd_header. Data beats are never consumed in this state.
  - e_wr_data: mem_cmd_data_yumi_o = mem_cmd_data_v_i. Each yumi writes the store at the current index and increments the counter. On the final beat's yumi go to e_wr_resp. Header yumi is held 0.
  - e_wr_resp: mem_resp_header_v_o = 1, carrying the latched header unchanged. On v & ready go to e_ready.
  - e_rd_header: mem_resp_header_v_o = 1 with the latched header. On v & ready go to e_rd_data.
  - e_rd_data: mem_resp_data_v_o = 1 and mem_resp_data_o = store[current index], read combinationally. On v & ready, increment the counter. After the final beat go to e_ready.
- Any msg_type other than e_mem_msg_wr is treated as a read, including uncached and prefetch types.
- Latency, all transfers back-to-back:
  - Read: header accepted cycle 0; response header cycle 1; data beats cycles 2..N+1.
  - Write: header cycle 0; data beats cycles 1..N; response header cycle N+1.
- One transaction in flight. A new header is accepted no earlier than the cycle after the previous response completes.
- Ready deasserted holds the outputs stable and valid: no valid drop, no data change.
- The valid outputs never depend combinationally on the ready inputs.
- A read immediately after a write to the same block returns the new data, because the write completes before its response.

Test Plan:
- Write size_64 (8 beats), addr 0x8000_0040, data 0x11..0x88 with data_v gapped every other cycle → 8 yumis, then one response header echoing the command. Read of the same address → header, then beats 0x11..0x88 in order.
- Read size_8 at addr 0x10 after writing 0xDEAD_BEEF there → exactly one data beat of 0xDEAD_BEEF, then state e_ready.
- Read with mem_resp_data_ready_i toggled randomly → every beat delivered exactly once, in order; data stable while v=1 and ready=0.
- Second header presented during e_wr_data → mem_cmd_header_yumi_o stays 0 until the first write's response handshake, then it is accepted the cycle after.
- Address wrap with mem_els_p=16: write 8 beats at word index 12 → words 12..15 and 0..3 written. A read at index 0 returns beat 4's data.
- reset_i pulsed after 3 of 8 write beats → outputs 0 the next cycle, no response header issued, and a fresh read is accepted immediately.
